// File: rtl/player_life_ctrl.sv
// Player life sequencer: limits collisions to one hit per frame, counts lives and runs the alive/dying/invulnerable/game-over flow.
// Latency: one cycle from the sampled start/frame_tick to the new state; every output is decoded from registers. No backpressure.
module player_life_ctrl #(
    parameter int LIVES_INIT    = 3,
    parameter int DYING_FRAMES  = 30,
    parameter int INVULN_FRAMES = 120,
    parameter int BLINK_SHIFT   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       collision,
    input  logic       start,
    output logic [1:0] lives,
    output logic [2:0] state,
    output logic       move_en,
    output logic       respawn,
    output logic       hit_sprite,
    output logic       player_visible,
    output logic       game_over
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ALIVE  = 3'd1,
        S_DYING  = 3'd2,
        S_INVULN = 3'd3,
        S_OVER   = 3'd4
    } state_t;

    localparam logic [7:0] DYING_LAST  = 8'(DYING_FRAMES - 1);
    localparam logic [7:0] INVULN_LAST = 8'(INVULN_FRAMES - 1);
    localparam logic [1:0] LIVES_LOAD  = 2'(LIVES_INIT);

    state_t     cur_state, nxt_state;
    logic [1:0] lives_q, lives_nxt;
    logic [7:0] frame_cnt, cnt_nxt;
    logic       hit_pend, pend_nxt;
    logic       respawn_q, respawn_nxt;
    logic       coll_live;
    logic       hit;
    logic       state_chg;

    // Collisions only count in ALIVE, and not in the cycle the sprite is being moved back to spawn.
    assign coll_live = collision && (cur_state == S_ALIVE) && !respawn_q;
    assign hit       = frame_tick && (hit_pend || coll_live);

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= S_IDLE;
            lives_q   <= 2'd0;
            frame_cnt <= 8'd0;
            hit_pend  <= 1'b0;
            respawn_q <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            lives_q   <= lives_nxt;
            frame_cnt <= cnt_nxt;
            hit_pend  <= pend_nxt;
            respawn_q <= respawn_nxt;
        end
    end

    always_comb begin
        nxt_state   = cur_state;
        lives_nxt   = lives_q;
        respawn_nxt = 1'b0;
        case (cur_state)
            S_IDLE, S_OVER: begin
                if (start) begin
                    nxt_state   = S_ALIVE;
                    lives_nxt   = LIVES_LOAD;
                    respawn_nxt = 1'b1;
                end
            end
            S_ALIVE: begin
                if (hit) begin
                    nxt_state = S_DYING;
                    if (lives_q != 2'd0) begin
                        lives_nxt = lives_q - 2'd1;
                    end
                end
            end
            S_DYING: begin
                if (frame_tick && (frame_cnt == DYING_LAST)) begin
                    if (lives_q == 2'd0) begin
                        nxt_state = S_OVER;
                    end else begin
                        nxt_state   = S_INVULN;
                        respawn_nxt = 1'b1;
                    end
                end
            end
            S_INVULN: begin
                if (frame_tick && (frame_cnt == INVULN_LAST)) begin
                    nxt_state = S_ALIVE;
                end
            end
            default: nxt_state = S_IDLE;
        endcase

        state_chg = (nxt_state != cur_state);

        // The counter only has meaning in the timed states, so it is frozen elsewhere.
        cnt_nxt = frame_cnt;
        if (state_chg) begin
            cnt_nxt = 8'd0;
        end else if (frame_tick && ((cur_state == S_DYING) || (cur_state == S_INVULN))) begin
            cnt_nxt = frame_cnt + 8'd1;
        end

        pend_nxt = hit_pend;
        if (state_chg || frame_tick) begin
            pend_nxt = 1'b0;
        end else if (coll_live) begin
            pend_nxt = 1'b1;
        end
    end

    always_comb begin
        move_en        = 1'b0;
        hit_sprite     = 1'b0;
        player_visible = 1'b0;
        game_over      = 1'b0;
        case (cur_state)
            S_ALIVE: begin
                move_en        = 1'b1;
                player_visible = 1'b1;
            end
            S_DYING: begin
                hit_sprite     = 1'b1;
                player_visible = 1'b1;
            end
            S_INVULN: begin
                move_en        = 1'b1;
                player_visible = ~frame_cnt[BLINK_SHIFT];
            end
            S_OVER: begin
                game_over = 1'b1;
            end
            default: ;
        endcase
    end

    assign state   = cur_state;
    assign lives   = lives_q;
    assign respawn = respawn_q;

endmodule

// File: tb/tb_player_life_ctrl.sv
// Directed bench for player_life_ctrl: stimulus pushes hand-computed expected outputs into a queue,
// a negedge monitor pops and compares them against the DUT.
module tb_player_life_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       collision = 1'b0;
    logic       start = 1'b0;
    logic [1:0] lives;
    logic [2:0] state;
    logic       move_en, respawn, hit_sprite, player_visible, game_over;

    player_life_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .frame_tick     (frame_tick),
        .collision      (collision),
        .start          (start),
        .lives          (lives),
        .state          (state),
        .move_en        (move_en),
        .respawn        (respawn),
        .hit_sprite     (hit_sprite),
        .player_visible (player_visible),
        .game_over      (game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        int         due;
        logic [9:0] vec;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: outputs are sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        logic [9:0] act;
        exp_t       e;
        act = {state, lives, move_en, respawn, hit_sprite, player_visible, game_over};
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            n_cmp++;
            if (e.due != cyc || act !== e.vec) begin
                n_bad++;
                $display("FAIL %s (cycle %0d): got st=%0d lv=%0d mv=%0b rs=%0b hs=%0b pv=%0b go=%0b, want st=%0d lv=%0d mv=%0b rs=%0b hs=%0b pv=%0b go=%0b",
                         e.name, cyc, act[9:7], act[6:5], act[4], act[3], act[2], act[1], act[0],
                         e.vec[9:7], e.vec[6:5], e.vec[4], e.vec[3], e.vec[2], e.vec[1], e.vec[0]);
            end
        end
    end

    task automatic cycle(input bit s, input bit t, input bit c, input bit r);
        start      = s;
        frame_tick = t;
        collision  = c;
        reset      = r;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int st, input int lv, input bit mv, input bit rs,
                       input bit hs, input bit pv, input bit go);
        exp_t e;
        e.name = name;
        e.due  = cyc;
        e.vec  = {3'(st), 2'(lv), mv, rs, hs, pv, go};
        sb.push_back(e);
    endtask

    // Called right after entering DYING with lv lives left; walks the full sequence under constant collision.
    task automatic run_death(input int lv);
        for (int i = 1; i <= 29; i++) begin
            cycle(0, 1, 1, 0);
            chk("dying_hold", 2, lv, 0, 0, 1, 1, 0);
        end
        cycle(0, 1, 1, 0);
        if (lv == 0) begin
            chk("dying_to_over", 4, 0, 0, 0, 0, 0, 1);
        end else begin
            chk("dying_to_invuln", 3, lv, 1, 1, 0, 1, 0);
            for (int k = 1; k <= 119; k++) begin
                cycle(0, 1, 1, 0);
                chk("invuln_blink", 3, lv, 1, 0, 0, ((k >> 2) & 1) == 0, 0);
            end
            cycle(0, 1, 1, 0);
            chk("invuln_to_alive", 1, lv, 1, 0, 0, 1, 0);
            cycle(0, 1, 0, 0);
            chk("alive_no_stale_hit", 1, lv, 1, 0, 0, 1, 0);
        end
    endtask

    initial begin
        cycle(0, 0, 0, 1);
        chk("reset", 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 1, 1, 1);
        chk("reset_over_start", 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 1, 0);
        chk("idle_tick", 0, 0, 0, 0, 0, 0, 0);

        cycle(1, 0, 0, 0);
        chk("start", 1, 3, 1, 1, 0, 1, 0);
        cycle(0, 0, 1, 0);
        chk("respawn_one_cycle", 1, 3, 1, 0, 0, 1, 0);
        cycle(0, 1, 0, 0);
        chk("respawn_coll_discard", 1, 3, 1, 0, 0, 1, 0);

        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 1, 0);
            chk("alive_coll_pending", 1, 3, 1, 0, 0, 1, 0);
        end
        cycle(0, 1, 0, 0);
        chk("hit1", 2, 2, 0, 0, 1, 1, 0);
        run_death(2);

        cycle(0, 1, 1, 0);
        chk("hit2_coll_on_tick", 2, 1, 0, 0, 1, 1, 0);
        run_death(1);

        cycle(0, 0, 1, 0);
        cycle(0, 0, 0, 0);
        chk("hit3_pending", 1, 1, 1, 0, 0, 1, 0);
        cycle(0, 1, 0, 0);
        chk("hit3", 2, 0, 0, 0, 1, 1, 0);
        run_death(0);
        cycle(0, 1, 1, 0);
        chk("over_hold", 4, 0, 0, 0, 0, 0, 1);

        cycle(1, 1, 0, 0);
        chk("restart_with_tick", 1, 3, 1, 1, 0, 1, 0);
        cycle(1, 0, 0, 0);
        chk("held_start_no_retrig", 1, 3, 1, 0, 0, 1, 0);
        cycle(1, 0, 1, 0);
        chk("held_start_alive", 1, 3, 1, 0, 0, 1, 0);
        cycle(1, 1, 0, 0);
        chk("held_start_hit", 2, 2, 0, 0, 1, 1, 0);
        cycle(1, 0, 0, 0);
        chk("held_start_dying", 2, 2, 0, 0, 1, 1, 0);

        for (int i = 1; i <= 9; i++) begin
            cycle(0, 1, 0, 0);
            chk("dying_pre_reset", 2, 2, 0, 0, 1, 1, 0);
        end
        cycle(0, 1, 0, 1);
        chk("reset_mid_dying", 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        chk("idle_after_reset", 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0);
        chk("start_after_reset", 1, 3, 1, 1, 0, 1, 0);
        cycle(0, 0, 0, 0);
        chk("alive_after_reset", 1, 3, 1, 0, 0, 1, 0);

        repeat (3) cycle(0, 0, 0, 0);
        if (sb.size() != 0) begin
            $display("FAIL scoreboard_drain: got %0d unchecked entries, want 0", sb.size());
            n_bad += sb.size();
            n_cmp += sb.size();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/player_life_ctrl.md
# player_life_ctrl

Sequencing controller for the player sprite in the STG play field. It turns the per-pixel `collision` level into at most one hit per video frame and tracks remaining lives. It runs the alive / dying / invulnerable / game-over sequence and drives the player datapath's control inputs: movement enable, respawn, hit-sprite select and blink mask. It sits between the collision detector, the VGA frame timing and the player sprite module.

## Interface
Parameters:
- `LIVES_INIT`, 3: lives loaded on game start (1..3).
- `DYING_FRAMES`, 30: frames spent in DYING (1..255).
- `INVULN_FRAMES`, 120: frames of post-respawn invulnerability (1..255).
- `BLINK_SHIFT`, 2: blink phase bit of the frame counter; toggles every 2^BLINK_SHIFT frames (0..7).

Ports:
- `clk`  in  1  system clock. One clock; every register is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `frame_tick`  in  1  one-cycle pulse, once per video frame.
- `collision`  in  1  player/bullet overlap level, valid during pixel scan.
- `start`  in  1  start request; level or pulse.
- `lives`  out  2  remaining lives.
- `state`  out  3  encoding: IDLE=0, ALIVE=1, DYING=2, INVULN=3, OVER=4.
- `move_en`  out  1  player may move.
- `respawn`  out  1  one-cycle pulse: player position returns to spawn (192,400).
- `hit_sprite`  out  1  select the hit image.
- `player_visible`  out  1  blink mask ANDed with the sprite's on signal.
- `game_over`  out  1  high in OVER.

## Operation
- Internal registers:
  - `state` (3 b), `lives` (2 b), `frame_cnt` (8 b).
  - `hit_pend`: set on any cycle with `collision`=1. Cleared on every `frame_tick` and on every state change.
  - `respawn` register.
- Hit condition at a tick: `hit` = `frame_tick` & (`hit_pend` | `collision`).
- Counting: `frame_cnt` clears to 0 on state entry. It increments only on `frame_tick` cycles.
- IDLE:
  - Outputs: `move_en`=0, `player_visible`=0.
  - `start`=1 goes to ALIVE, loads `lives`=LIVES_INIT and pulses `respawn`.
- ALIVE:
  - Outputs: `move_en`=1, `player_visible`=1, `hit_sprite`=0.
  - On `hit`: `lives` decrements and the state goes to DYING.
- DYING:
  - Outputs: `move_en`=0, `hit_sprite`=1, `player_visible`=1. Collisions are ignored.
  - On the tick where `frame_cnt`==DYING_FRAMES-1:
    - If `lives`==0, go to OVER.
    - Otherwise go to INVULN and pulse `respawn`.
- INVULN:
  - Outputs: `move_en`=1, `hit_sprite`=0, `player_visible`=~`frame_cnt[BLINK_SHIFT]`. Collisions are ignored.
  - On the tick where `frame_cnt`==INVULN_FRAMES-1, go to ALIVE (no respawn).
- OVER:
  - Outputs: `game_over`=1, `move_en`=0, `player_visible`=0. `lives` holds 0.
  - `start`=1 behaves as in IDLE.
- Arithmetic:
  - `lives` never underflows.
  - A decrement happens only in ALIVE, where `lives`≥1 by construction.
  - `frame_cnt` never wraps within a legal parameter range.

## Timing
- Reset values: `state`=IDLE, `lives`=0, `frame_cnt`=0, `hit_pend`=0, `respawn`=0.
- Outputs in reset: `move_en`=0, `hit_sprite`=0, `player_visible`=0, `game_over`=0.
- Reset takes effect on the next edge, overrides every other input, and generates no `respawn` pulse. This applies in every state, including mid-DYING and mid-INVULN.
- All outputs are decoded from registers only; there is no combinational input-to-output path.
- Transition latency: a state change is visible the cycle after the edge that samples the triggering `start` or `frame_tick`.
- `respawn` is high for exactly that one cycle.
- Hit latency: a collision anywhere in frame N gives DYING on the cycle after frame N's closing `frame_tick`. There is at most one hit per frame.
- Collision in the same cycle as `frame_tick` counts for the frame that is closing.
- `start` and `frame_tick` together in IDLE/OVER: `start` wins; that tick is not counted in ALIVE.
- `start` is ignored outside IDLE/OVER. A held `start` does not retrigger after entry to ALIVE.
- Collision during the `respawn` cycle or during INVULN is discarded. `hit_pend` is 0 on entry to ALIVE.

## Test plan
- Reset, then `start` pulse: next cycle `state`=1, `lives`=3, `respawn`=1 for 1 cycle, `move_en`=1.
- In ALIVE, `collision` high for 5 cycles mid-frame, then `frame_tick`: next cycle `state`=2, `lives`=2, `hit_sprite`=1, `move_en`=0. Exactly one decrement.
- After the 30th tick in DYING: `state`=3 and a `respawn` pulse. `player_visible` toggles every 4 ticks. Continuous `collision` is ignored. After 120 ticks, `state`=1.
- Three hits with full sequences: the third DYING ends in `state`=4, `game_over`=1, `lives`=0, no `respawn`. Then `start`+`frame_tick` in the same cycle gives `state`=1, `lives`=3.
- `reset` asserted in DYING on tick 10: next cycle all outputs are at reset values, `respawn`=0. The following `start` behaves normally.
- Hold `start` high through ALIVE and a hit: no extra `respawn` or `lives` reload occurs.
